mtimer_clint: RTL and testbench

//  Memory-mapped 64-bit machine timer (CLINT-style mtime/mtimecmp) on the clk_main domain.

---
 rtl/mtimer_clint.sv | 142 ++++++++++++++
 tb/tb_mtimer_clint.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/mtimer_clint.sv
// Memory-mapped 64-bit machine timer (mtime/mtimecmp) with prescaler,
// level interrupt, and optional periodic auto-reload of the compare value.
module mtimer_clint #(
    parameter logic [31:0] PRESCALE_RST = 32'd0,
    parameter logic [31:0] PERIOD_RST   = 32'd10000000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [2:0]  a,
    input  logic [31:0] d,
    input  logic        we,
    input  logic        rd,
    output logic [31:0] spo,
    output logic        ready,
    output logic        irq
);

    typedef enum logic {IDLE, PEND} pend_e;

    pend_e       state_q, state_d;
    logic [63:0] mtime_q, mtime_d;
    logic [63:0] cmp_q, cmp_d;
    logic [2:0]  ctrl_q, ctrl_d;
    logic [31:0] prescale_q, prescale_d;
    logic [31:0] period_q, period_d;
    logic [31:0] pcnt_q, pcnt_d;
    logic [31:0] shadow_q, shadow_d;
    logic [31:0] spo_q, spo_d;
    logic        ready_q, ready_d;
    logic        irq_q, irq_d;

    logic        enable;
    logic        irq_en;
    logic        autoreload;
    logic        tick;
    logic        match;
    logic        set;
    logic        clr;
    logic [31:0] rdata;

    assign enable     = ctrl_q[0];
    assign irq_en     = ctrl_q[1];
    assign autoreload = ctrl_q[2];
    assign tick       = enable && (pcnt_q == prescale_q);
    assign match      = (mtime_q >= cmp_q);
    assign set        = match && enable;
    assign clr        = we && (a == 3'd7) && d[0];

    always_comb begin
        rdata = 32'd0;
        unique case (a)
            3'd0: rdata = mtime_q[31:0];
            3'd1: rdata = shadow_q;
            3'd2: rdata = cmp_q[31:0];
            3'd3: rdata = cmp_q[63:32];
            3'd4: rdata = {29'd0, ctrl_q};
            3'd5: rdata = prescale_q;
            3'd6: rdata = period_q;
            3'd7: rdata = {31'd0, state_q == PEND};
        endcase
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (set) state_d = PEND;
            PEND: if (clr && !set) state_d = IDLE;
        endcase
    end

    always_comb begin
        mtime_d    = mtime_q;
        cmp_d      = cmp_q;
        ctrl_d     = ctrl_q;
        prescale_d = prescale_q;
        period_d   = period_q;
        pcnt_d     = pcnt_q;
        shadow_d   = shadow_q;
        spo_d      = spo_q;
        ready_d    = we || rd;
        irq_d      = (state_q == PEND) && irq_en;

        if (enable) pcnt_d = tick ? 32'd0 : pcnt_q + 32'd1;
        if (tick) mtime_d = mtime_q + 64'd1;
        if (set && autoreload) cmp_d = cmp_q + {32'd0, period_q};

        // Software writes override the tick and the reload on the same edge
        if (we) begin
            unique case (a)
                3'd0: mtime_d = {mtime_q[63:32], d};
                3'd1: mtime_d = {d, mtime_q[31:0]};
                3'd2: cmp_d = {cmp_q[63:32], d};
                3'd3: cmp_d = {d, cmp_q[31:0]};
                3'd4: ctrl_d = d[2:0];
                3'd5: begin
                    prescale_d = d;
                    pcnt_d     = 32'd0;
                end
                3'd6: period_d = d;
                3'd7: ;
            endcase
        end

        if (rd) begin
            spo_d = rdata;
            if (a == 3'd0) shadow_d = mtime_q[63:32];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            mtime_q    <= 64'd0;
            cmp_q      <= 64'hFFFF_FFFF_FFFF_FFFF;
            ctrl_q     <= 3'd0;
            prescale_q <= PRESCALE_RST;
            period_q   <= PERIOD_RST;
            pcnt_q     <= 32'd0;
            shadow_q   <= 32'd0;
            spo_q      <= 32'd0;
            ready_q    <= 1'b0;
            irq_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            mtime_q    <= mtime_d;
            cmp_q      <= cmp_d;
            ctrl_q     <= ctrl_d;
            prescale_q <= prescale_d;
            period_q   <= period_d;
            pcnt_q     <= pcnt_d;
            shadow_q   <= shadow_d;
            spo_q      <= spo_d;
            ready_q    <= ready_d;
            irq_q      <= irq_d;
        end
    end

    assign spo   = spo_q;
    assign ready = ready_q;
    assign irq   = irq_q;

endmodule

// File: tb/tb_mtimer_clint.sv
// Directed bench for mtimer_clint: register map, prescaler, shadow read,
// compare/irq, auto-reload and reset behaviour.
module tb_mtimer_clint;

    logic        clk;
    logic        rst_n;
    logic [2:0]  a;
    logic [31:0] d;
    logic        we;
    logic        rd;
    logic [31:0] spo;
    logic        ready;
    logic        irq;

    int n_checks = 0;
    int n_errors = 0;

    mtimer_clint dut (
        .clk   (clk),
        .rst_n (rst_n),
        .a     (a),
        .d     (d),
        .we    (we),
        .rd    (rd),
        .spo   (spo),
        .ready (ready),
        .irq   (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // All tasks start and end at a falling edge
    task automatic wr(input logic [2:0] ad, input logic [31:0] dd);
        a  = ad;
        d  = dd;
        we = 1'b1;
        @(negedge clk);
        we = 1'b0;
    endtask

    task automatic rdreg(input logic [2:0] ad, output logic [31:0] v);
        a  = ad;
        rd = 1'b1;
        @(negedge clk);
        rd = 1'b0;
        check("rd_ready", ready, 1);
        v = spo;
    endtask

    logic [31:0] v;
    logic [31:0] rst_exp [8];

    initial begin
        rst_exp[0] = 32'd0;
        rst_exp[1] = 32'd0;
        rst_exp[2] = 32'hFFFF_FFFF;
        rst_exp[3] = 32'hFFFF_FFFF;
        rst_exp[4] = 32'd0;
        rst_exp[5] = 32'd0;
        rst_exp[6] = 32'd10000000;
        rst_exp[7] = 32'd0;

        rst_n = 1'b0;
        a = 3'd0;
        d = 32'd0;
        we = 1'b0;
        rd = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_spo", spo, 0);
        check("rst_ready", ready, 0);
        check("rst_irq", irq, 0);
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) begin
            rdreg(3'(i), v);
            check($sformatf("rst_reg%0d", i), v, rst_exp[i]);
        end
        @(negedge clk);
        check("ready_one_cycle", ready, 0);

        // prescaler: tick every 4 cycles
        wr(3'd5, 32'd3);
        wr(3'd4, 32'd1);
        repeat (40) @(negedge clk);
        rdreg(3'd0, v);
        check("prescale_run", v, 10);
        wr(3'd4, 32'd0);
        rdreg(3'd0, v);
        check("freeze_a", v, 10);
        repeat (20) @(negedge clk);
        rdreg(3'd0, v);
        check("freeze_b", v, 10);

        // 64-bit carry and shadow
        wr(3'd5, 32'd0);
        wr(3'd0, 32'hFFFF_FFFE);
        wr(3'd1, 32'd0);
        wr(3'd4, 32'd1);
        repeat (3) @(negedge clk);
        rdreg(3'd0, v);
        check("carry_lo", v, 1);
        rdreg(3'd1, v);
        check("carry_hi", v, 1);
        wr(3'd0, 32'hFFFF_FFF0);
        wr(3'd1, 32'd0);
        rdreg(3'd0, v);
        check("shadow_lo", v, 32'hFFFF_FFF0);
        repeat (20) @(negedge clk);
        rdreg(3'd1, v);
        check("shadow_hi", v, 0);
        rdreg(3'd0, v);
        rdreg(3'd1, v);
        check("fresh_hi", v, 1);

        // compare and irq
        wr(3'd4, 32'd0);
        wr(3'd0, 32'd0);
        wr(3'd1, 32'd0);
        wr(3'd3, 32'd0);
        wr(3'd2, 32'd20);
        wr(3'd4, 32'd3);
        repeat (21) @(negedge clk);
        check("irq_before", irq, 0);
        @(negedge clk);
        check("irq_after", irq, 1);
        rdreg(3'd7, v);
        check("status_pend", v, 1);
        wr(3'd3, 32'hFFFF_FFFF);
        wr(3'd7, 32'd1);
        @(negedge clk);
        check("irq_cleared", irq, 0);
        rdreg(3'd7, v);
        check("status_clr", v, 0);
        wr(3'd4, 32'd1);
        wr(3'd3, 32'd0);
        repeat (3) @(negedge clk);
        check("irq_masked", irq, 0);
        rdreg(3'd7, v);
        check("status_masked", v, 1);
        wr(3'd7, 32'd1);
        rdreg(3'd7, v);
        check("set_wins", v, 1);
        rdreg(3'd4, v);
        check("ctrl_rd", v, 1);

        // auto-reload
        wr(3'd4, 32'd0);
        wr(3'd3, 32'hFFFF_FFFF);
        wr(3'd7, 32'd1);
        wr(3'd0, 32'd0);
        wr(3'd1, 32'd0);
        wr(3'd6, 32'd8);
        wr(3'd2, 32'd8);
        wr(3'd3, 32'd0);
        wr(3'd4, 32'd7);
        repeat (9) @(negedge clk);
        rdreg(3'd2, v);
        check("reload_16", v, 16);
        check("ar_irq1", irq, 1);
        wr(3'd7, 32'd1);
        @(negedge clk);
        check("ar_irq1_clr", irq, 0);
        repeat (6) @(negedge clk);
        rdreg(3'd2, v);
        check("reload_24", v, 24);
        check("ar_irq2", irq, 1);
        wr(3'd7, 32'd1);
        repeat (6) @(negedge clk);
        rdreg(3'd2, v);
        check("reload_32", v, 32);
        repeat (5) @(negedge clk);
        wr(3'd2, 32'd100);
        rdreg(3'd2, v);
        check("cmp_wr_wins", v, 100);
        check("irq_pre_rst", irq, 1);

        // reset in the middle of a read
        a  = 3'd6;
        rd = 1'b1;
        #2 rst_n = 1'b0;
        @(negedge clk);
        rd = 1'b0;
        check("rst_mid_ready", ready, 0);
        check("rst_mid_irq", irq, 0);
        check("rst_mid_spo", spo, 0);
        @(negedge clk);
        check("rst_mid_ready2", ready, 0);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            rdreg(3'(i), v);
            check($sformatf("rst2_reg%0d", i), v, rst_exp[i]);
        end
        check("rst2_irq", irq, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
